refill_ctrl: RTL and testbench

// Miss-refill engine, directly downstream of main_fsm's address-request handshake.
// - Takes the miss address from main_fsm (addr_req_o/addr_o).
// - Issues one AXI4 INCR read burst for the whole cache line and assembles the beats.
// - Writes tag+line into the cache storage, then pulses done_o, which drives main_fsm addr_ready_i.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/refill_ctrl_line_buf.sv | 36 +++
 rtl/refill_ctrl.sv | 135 +++++++++++++
 tb/tb_refill_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache types and sizing helpers.
// Address/data geometry, refill FSM states and AXI response codes.
package cache_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int DATA_BYTES = DATA_WIDTH / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    BEAT,
    FILL
  } refill_state_t;

  function automatic int offset_w(
    input int line_words
  );
    return $clog2(line_words * DATA_BYTES);
  endfunction

  function automatic int tag_w(
    input int line_words,
    input int index_width
  );
    return ADDR_WIDTH - index_width
           - offset_w(line_words);
  endfunction

endpackage

// File: rtl/refill_ctrl_line_buf.sv
// Word-addressed line assembly buffer.
// Out-of-range indices are dropped so a long burst never wraps.
module refill_line_buf
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 3
) (
  input  logic                             aclk_i,
  input  logic                             arstn_i,
  input  logic                             clr_i,
  input  logic                             we_i,
  input  logic [CNT_W-1:0]                 idx_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_o
);

  logic in_range;

  assign in_range = idx_i < CNT_W'(LINE_WORDS);

  always_ff @(posedge aclk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      line_o <= '0;
    end else if (clr_i) begin
      line_o <= '0;
    end else if (we_i && in_range) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (idx_i == CNT_W'(k)) begin
          line_o[k*DATA_WIDTH +: DATA_WIDTH] <= data_i;
        end
      end
    end
  end

endmodule

// File: rtl/refill_ctrl.sv
// Miss-refill engine: one AXI4 INCR burst per line,
// then a single tag+line write and a done pulse.
module refill_ctrl
  import cache_pkg::*;
#(
  parameter  int LINE_WORDS  = 4,
  parameter  int INDEX_WIDTH = 6,
  localparam int OFFSET_W    = offset_w(LINE_WORDS),
  localparam int TAG_W       = tag_w(LINE_WORDS, INDEX_WIDTH)
) (
  input  logic                             aclk_i,
  input  logic                             arstn_i,
  input  logic                             req_i,
  input  logic [ADDR_WIDTH-1:0]            req_addr_i,
  output logic                             done_o,
  output logic                             err_o,
  output logic                             ar_valid_o,
  output logic [ADDR_WIDTH-1:0]            ar_addr_o,
  output logic [7:0]                       ar_len_o,
  input  logic                             ar_ready_i,
  input  logic                             r_valid_i,
  input  logic [DATA_WIDTH-1:0]            r_data_i,
  input  logic [1:0]                       r_resp_i,
  input  logic                             r_last_i,
  output logic                             r_ready_o,
  output logic                             line_we_o,
  output logic [INDEX_WIDTH-1:0]           line_index_o,
  output logic [TAG_W-1:0]                 line_tag_o,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_data_o
);

  // One extra bit so overrun beats are distinguishable.
  localparam int CNT_W = $clog2(LINE_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT =
    CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [7:0] AR_LEN =
    8'(LINE_WORDS - 1);

  refill_state_t state, nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_q;
  logic                  start;
  logic                  beat_fire;
  logic                  beat_bad;

  assign start     = (state == IDLE) && req_i;
  assign beat_fire = (state == BEAT) && r_valid_i;
  assign beat_bad  = r_resp_i[1]
                   | (r_last_i && (cnt_q != LAST_CNT))
                   | (cnt_q >= FULL_CNT);

  always_ff @(posedge aclk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state  <= IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (start) begin
        addr_q <= req_addr_i;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end
      if (beat_fire) begin
        // Saturate so a runaway burst keeps flagging.
        if (cnt_q != MAX_CNT) begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (beat_bad) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt        = state;
    ar_valid_o = 1'b0;
    r_ready_o  = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    line_we_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i) nxt = AR;
      end
      AR: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) nxt = BEAT;
      end
      BEAT: begin
        r_ready_o = 1'b1;
        if (r_valid_i && r_last_i) nxt = FILL;
      end
      FILL: begin
        done_o    = 1'b1;
        err_o     = err_q;
        line_we_o = !err_q;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign ar_addr_o = {
    addr_q[ADDR_WIDTH-1:OFFSET_W],
    {OFFSET_W{1'b0}}
  };
  assign ar_len_o = ar_valid_o ? AR_LEN : 8'd0;

  assign line_index_o =
    addr_q[OFFSET_W +: INDEX_WIDTH];
  assign line_tag_o =
    addr_q[ADDR_WIDTH-1 -: TAG_W];

  refill_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .CNT_W      (CNT_W)
  ) u_buf (
    .aclk_i  (aclk_i),
    .arstn_i (arstn_i),
    .clr_i   (start),
    .we_i    (beat_fire),
    .idx_i   (cnt_q),
    .data_i  (r_data_i),
    .line_o  (line_data_o)
  );

endmodule

// File: tb/tb_refill_ctrl.sv
// Scoreboard bench for refill_ctrl.
// Driver queues expectations; negedge monitor checks them.
module tb_refill_ctrl;
  import cache_pkg::*;

  logic         aclk_i = 1'b0;
  logic         arstn_i = 1'b0;
  logic         req_i = 1'b0;
  logic [31:0]  req_addr_i = '0;
  logic         done_o, err_o;
  logic         ar_valid_o;
  logic [31:0]  ar_addr_o;
  logic [7:0]   ar_len_o;
  logic         ar_ready_i = 1'b0;
  logic         r_valid_i = 1'b0;
  logic [31:0]  r_data_i = '0;
  logic [1:0]   r_resp_i = '0;
  logic         r_last_i = 1'b0;
  logic         r_ready_o;
  logic         line_we_o;
  logic [5:0]   line_index_o;
  logic [21:0]  line_tag_o;
  logic [127:0] line_data_o;

  always #5 aclk_i = ~aclk_i;

  refill_ctrl dut (
    .aclk_i       (aclk_i),
    .arstn_i      (arstn_i),
    .req_i        (req_i),
    .req_addr_i   (req_addr_i),
    .done_o       (done_o),
    .err_o        (err_o),
    .ar_valid_o   (ar_valid_o),
    .ar_addr_o    (ar_addr_o),
    .ar_len_o     (ar_len_o),
    .ar_ready_i   (ar_ready_i),
    .r_valid_i    (r_valid_i),
    .r_data_i     (r_data_i),
    .r_resp_i     (r_resp_i),
    .r_last_i     (r_last_i),
    .r_ready_o    (r_ready_o),
    .line_we_o    (line_we_o),
    .line_index_o (line_index_o),
    .line_tag_o   (line_tag_o),
    .line_data_o  (line_data_o)
  );

  typedef struct packed {
    logic         err;
    logic         we;
    logic [5:0]   idx;
    logic [21:0]  tag;
    logic [127:0] data;
    logic         chk_data;
    logic [7:0]   lat;
  } exp_t;

  exp_t        done_q[$];
  logic [31:0] ar_q[$];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    t0 = 0;
  int    tmo_req = 0;
  int    tmo_seen = 0;
  string tmo_name = "";
  bit    end_req = 1'b0;

  always @(posedge aclk_i) cyc <= cyc + 1;

  function automatic exp_t mk(
    input logic err, input logic we,
    input logic [5:0] idx, input logic [21:0] tag,
    input logic [127:0] data, input logic chk,
    input logic [7:0] lat
  );
    exp_t e;
    e.err = err; e.we = we; e.idx = idx;
    e.tag = tag; e.data = data;
    e.chk_data = chk; e.lat = lat;
    return e;
  endfunction

  function automatic void chk(
    input string n,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endfunction

  // Monitor: the only process that counts comparisons.
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge aclk_i) begin
    exp_t e;
    logic [31:0] a;
    if (tmo_req != tmo_seen) begin
      checks++; errors++;
      $display("FAIL timeout %s got expired want event",
               tmo_name);
      tmo_seen = tmo_req;
    end
    if (!arstn_i) begin
      chk("reset_outputs",
          128'({done_o, err_o, ar_valid_o, ar_addr_o,
                ar_len_o, r_ready_o, line_we_o,
                line_index_o, line_tag_o})
          | line_data_o, '0);
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("ar_hold_valid", 128'(ar_valid_o), 128'(1));
        chk("ar_hold_addr", 128'(ar_addr_o),
            128'(prev_addr));
      end
      if (ar_valid_o && ar_ready_i) begin
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", 128'(1), 128'(0));
        end else begin
          a = ar_q.pop_front();
          chk("ar_addr", 128'(ar_addr_o), 128'(a));
          chk("ar_len", 128'(ar_len_o), 128'(3));
        end
      end
      prev_wait = ar_valid_o && !ar_ready_i;
      prev_addr = ar_addr_o;
      if (done_o) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 128'(1), 128'(0));
        end else begin
          e = done_q.pop_front();
          chk("err", 128'(err_o), 128'(e.err));
          chk("we", 128'(line_we_o), 128'(e.we));
          chk("index", 128'(line_index_o), 128'(e.idx));
          chk("tag", 128'(line_tag_o), 128'(e.tag));
          if (e.chk_data)
            chk("data", line_data_o, e.data);
          if (e.lat != 0)
            chk("latency", 128'(cyc - t0), 128'(e.lat));
        end
      end
    end
    if (end_req) begin
      chk("pending_exp",
          128'(done_q.size() + ar_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic tick();
    @(posedge aclk_i);
    #1;
  endtask

  task automatic timeout(input string n);
    tmo_name = n;
    tmo_req++;
  endtask

  task automatic wait_ar();
    int n = 0;
    while (1) begin
      @(negedge aclk_i);
      if (ar_valid_o && ar_ready_i) break;
      if (++n > 50) begin timeout("ar"); break; end
    end
    tick();
  endtask

  task automatic refill(
    input logic [31:0] addr, input int nb,
    input int last_k, input int err_k,
    input int ar_delay, input int gap,
    input logic [31:0] base, input exp_t e,
    input logic [31:0] ar_exp
  );
    int n;
    ar_q.push_back(ar_exp);
    done_q.push_back(e);
    req_i = 1'b1;
    req_addr_i = addr;
    ar_ready_i = (ar_delay == 0);
    t0 = cyc;
    if (ar_delay != 0) begin
      repeat (ar_delay + 1) tick();
      ar_ready_i = 1'b1;
    end
    wait_ar();
    for (int k = 0; k < nb; k++) begin
      repeat (gap) tick();
      r_valid_i = 1'b1;
      r_data_i  = base + 32'(k);
      r_resp_i  = (k == err_k) ? 2'b10 : 2'b00;
      r_last_i  = (k == last_k);
      n = 0;
      while (1) begin
        @(negedge aclk_i);
        if (r_ready_o) break;
        if (++n > 50) begin timeout("r_ready"); break; end
      end
      tick();
      r_valid_i = 1'b0;
      r_last_i  = 1'b0;
      r_resp_i  = 2'b00;
    end
    n = 0;
    while (1) begin
      @(negedge aclk_i);
      if (done_o) break;
      if (++n > 50) begin timeout("done"); break; end
    end
    tick();
    req_i = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    repeat (3) tick();
    arstn_i = 1'b1;
    tick();

    refill(32'h0000_1234, 4, 3, -1, 0, 0, 32'hA0,
           mk(0, 1, 6'h23, 22'h4,
              {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, 6),
           32'h0000_1230);

    refill(32'h0000_ABC8, 4, 3, -1, 3, 2, 32'hB0,
           mk(0, 1, 6'h3C, 22'h2A,
              {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1, 0),
           32'h0000_ABC0);

    refill(32'h0001_0008, 4, 3, 2, 0, 0, 32'hC0,
           mk(1, 0, 6'h00, 22'h40,
              {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1, 6),
           32'h0001_0000);

    refill(32'h0000_0FF0, 2, 1, -1, 0, 0, 32'hE0,
           mk(1, 0, 6'h3F, 22'h3, '0, 0, 4),
           32'h0000_0FF0);

    refill(32'h0000_0400, 6, 5, -1, 0, 0, 32'hD0,
           mk(1, 0, 6'h00, 22'h1,
              {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1, 8),
           32'h0000_0400);

    // Abandon a burst two beats in.
    ar_q.push_back(32'h0000_0080);
    req_i = 1'b1;
    req_addr_i = 32'h0000_0084;
    ar_ready_i = 1'b1;
    wait_ar();
    r_valid_i = 1'b1;
    r_data_i  = 32'h55;
    repeat (2) tick();
    arstn_i   = 1'b0;
    req_i     = 1'b0;
    r_valid_i = 1'b0;
    repeat (3) tick();
    arstn_i = 1'b1;
    tick();

    refill(32'h0000_0040, 4, 3, -1, 0, 0, 32'hF0,
           mk(0, 1, 6'h04, 22'h0,
              {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1, 6),
           32'h0000_0040);

    end_req = 1'b1;
    repeat (5) tick();
    $display("FAIL monitor got no_summary want summary");
    $fatal(1);
  end

endmodule
